// File: rtl/counter_timer_dev_pkg.sv
// Shared constants and helpers for the three-channel down-counter peripheral.
package counter_timer_dev_pkg;

    localparam logic [1:0] SEL_CH0  = 2'b00;
    localparam logic [1:0] SEL_CH1  = 2'b01;
    localparam logic [1:0] SEL_CH2  = 2'b10;
    localparam logic [1:0] SEL_CTRL = 2'b11;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int TC_LSB = 12;

    function automatic int en_bit(input int n);
        return 4 * n;
    endfunction

    function automatic int mode_bit(input int n);
        return (4 * n) + 1;
    endfunction

    // Assemble the control register image; unused bits read as zero.
    function automatic logic [31:0] ctrl_word(input logic [2:0] en,
                                              input logic [2:0] mode,
                                              input logic [2:0] tc);
        logic [31:0] w;
        w = 32'h0000_0000;
        for (int n = 0; n < 3; n++) begin
            w[en_bit(n)]   = en[n];
            w[mode_bit(n)] = mode[n];
        end
        w[TC_LSB +: 3] = tc;
        return w;
    endfunction

endpackage

// File: rtl/counter_timer_dev_if.sv
// Bus-side signals of the counter/timer: write strobe, data, select, readback and channel outputs.
interface counter_timer_dev_if;
    logic        counter_we;
    logic [31:0] counter_val;
    logic [1:0]  counter_set;
    logic [31:0] counter_out;
    logic        counter0_out;
    logic        counter1_out;
    logic        counter2_out;

    modport master (
        output counter_we, counter_val, counter_set,
        input  counter_out, counter0_out, counter1_out, counter2_out
    );

    modport slave (
        input  counter_we, counter_val, counter_set,
        output counter_out, counter0_out, counter1_out, counter2_out
    );
endinterface

// File: rtl/counter_timer_dev_channel.sv
// One down-counter channel: count, reload value, output bit and a one-cycle terminal-count pulse.
module counter_channel
    import counter_timer_dev_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic             mode_chg,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             out,
    output logic             tc
);

    logic [CNT_W-1:0] count_r, count_s;
    logic [CNT_W-1:0] reload_r, reload_s;
    logic             out_r, out_cnt_s, out_s;
    logic             tc_s;

    // Next-state: a load beats a terminal count, and a mode change forces the output low.
    always_comb begin
        count_s   = count_r;
        reload_s  = reload_r;
        out_cnt_s = out_r;
        tc_s      = 1'b0;
        if (load) begin
            count_s  = load_val;
            reload_s = load_val;
            if (mode == MODE_ONESHOT) begin
                out_cnt_s = 1'b0;
            end else begin
                out_cnt_s = out_r;
            end
        end else if (en && (count_r != {CNT_W{1'b0}})) begin
            if (count_r == CNT_W'(1)) begin
                tc_s = 1'b1;
                if (mode == MODE_PERIODIC) begin
                    count_s   = reload_r;
                    out_cnt_s = ~out_r;
                end else begin
                    count_s   = {CNT_W{1'b0}};
                    out_cnt_s = 1'b1;
                end
            end else begin
                count_s = count_r - CNT_W'(1);
            end
        end else begin
            count_s = count_r;
        end
        out_s = mode_chg ? 1'b0 : out_cnt_s;
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r  <= {CNT_W{1'b0}};
            reload_r <= {CNT_W{1'b0}};
            out_r    <= 1'b0;
        end else begin
            count_r  <= count_s;
            reload_r <= reload_s;
            out_r    <= out_s;
        end
    end

    assign count = count_r;
    assign out   = out_r;
    assign tc    = tc_s;

endmodule

// File: rtl/counter_timer_dev.sv
// Three-channel programmable down-counter: control/flag register, write decode and registered readback.
module counter_timer_dev
    import counter_timer_dev_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    counter_timer_dev_if.slave  bus
);

    logic [2:0]       en_r, mode_r, tc_r;
    logic [2:0]       load_s, mode_chg_s, tc_s, out_s;
    logic [CNT_W-1:0] count_s [3];
    logic             ctrl_we_s;
    logic [31:0]      rdata_s, counter_out_r;

    assign ctrl_we_s = bus.counter_we && (bus.counter_set == SEL_CTRL);

    for (genvar g = 0; g < 3; g++) begin : g_ch
        assign load_s[g]     = bus.counter_we && (bus.counter_set == 2'(g));
        assign mode_chg_s[g] = ctrl_we_s && (bus.counter_val[mode_bit(g)] != mode_r[g]);

        counter_channel #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en_r[g]),
            .mode     (mode_r[g]),
            .load     (load_s[g]),
            .mode_chg (mode_chg_s[g]),
            .load_val (bus.counter_val[CNT_W-1:0]),
            .count    (count_s[g]),
            .out      (out_s[g]),
            .tc       (tc_s[g])
        );
    end

    // Control fields and sticky flags; a control write clears flags even against a same-cycle event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_r   <= 3'b000;
            mode_r <= 3'b000;
            tc_r   <= 3'b000;
        end else if (ctrl_we_s) begin
            en_r   <= {bus.counter_val[en_bit(2)], bus.counter_val[en_bit(1)], bus.counter_val[en_bit(0)]};
            mode_r <= {bus.counter_val[mode_bit(2)], bus.counter_val[mode_bit(1)], bus.counter_val[mode_bit(0)]};
            tc_r   <= 3'b000;
        end else begin
            tc_r   <= tc_r | tc_s;
        end
    end

    // Readback selection; channel selects show the live count.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (bus.counter_set)
            SEL_CH0:  rdata_s = 32'(count_s[0]);
            SEL_CH1:  rdata_s = 32'(count_s[1]);
            SEL_CH2:  rdata_s = 32'(count_s[2]);
            SEL_CTRL: rdata_s = ctrl_word(en_r, mode_r, tc_r);
            default:  rdata_s = 32'h0000_0000;
        endcase
    end

    // Registered readback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter_out_r <= 32'h0000_0000;
        end else begin
            counter_out_r <= rdata_s;
        end
    end

    assign bus.counter_out  = counter_out_r;
    assign bus.counter0_out = out_s[0];
    assign bus.counter1_out = out_s[1];
    assign bus.counter2_out = out_s[2];

endmodule

// File: tb/tb_counter_timer_dev.sv
// Directed self-checking bench for counter_timer_dev; inputs change and outputs are sampled on the falling edge.
module tb_counter_timer_dev;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    counter_timer_dev_if bus ();

    counter_timer_dev #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One-cycle write; counter_set is left at the written select afterwards.
    task automatic wr(input logic [1:0] sel, input logic [31:0] val);
        bus.counter_we  = 1'b1;
        bus.counter_set = sel;
        bus.counter_val = val;
        step();
        bus.counter_we  = 1'b0;
        bus.counter_val = 32'h0000_0000;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b0;
        bus.counter_we  = 1'b0;
        bus.counter_val = 32'h0000_0000;
        bus.counter_set = 2'b00;

        // Reset state
        #2;
        check("rst_out",  bus.counter_out, 32'h0);
        check("rst_outs", {29'h0, bus.counter2_out, bus.counter1_out, bus.counter0_out}, 32'h0);
        step();
        rst = 1'b1;
        bus.counter_set = 2'b11;
        step();
        check("rst_ctrl", bus.counter_out, 32'h0);

        // Channel 0 one-shot, count 5
        wr(2'b11, 32'h1);
        wr(2'b00, 32'd5);
        check("os_load_out", {31'h0, bus.counter0_out}, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("os_wait_out", {31'h0, bus.counter0_out}, 32'h0);
        end
        step();
        check("os_fire_out", {31'h0, bus.counter0_out}, 32'h1);
        bus.counter_set = 2'b11;
        step();
        check("os_ctrl", bus.counter_out, 32'h0000_1001);
        bus.counter_set = 2'b00;
        step();
        check("os_count0", bus.counter_out, 32'h0);

        // Channel 1 periodic, reload 3
        wr(2'b11, 32'h30);
        wr(2'b01, 32'd3);
        check("per_out0", {31'h0, bus.counter1_out}, 32'h0);
        for (int j = 1; j <= 24; j++) begin
            step();
            check("per_out", {31'h0, bus.counter1_out}, 32'((j / 3) % 2));
            check("per_cnt", bus.counter_out, 32'(3 - ((j - 1) % 3)));
        end

        // Channel 2 periodic, freeze on disable and resume
        wr(2'b11, 32'h300);
        wr(2'b10, 32'd4);
        step();
        check("frz_cnt4", bus.counter_out, 32'd4);
        wr(2'b11, 32'h200);
        bus.counter_set = 2'b10;
        for (int h = 0; h < 10; h++) begin
            step();
            check("frz_hold", bus.counter_out, 32'd2);
            check("frz_out", {31'h0, bus.counter2_out}, 32'h0);
        end
        wr(2'b11, 32'h300);
        bus.counter_set = 2'b10;
        step();
        check("res_out1", {31'h0, bus.counter2_out}, 32'h0);
        check("res_cnt1", bus.counter_out, 32'd2);
        step();
        check("res_out2", {31'h0, bus.counter2_out}, 32'h1);
        check("res_cnt2", bus.counter_out, 32'd1);

        // Write colliding with terminal count on channel 0
        wr(2'b11, 32'h1);
        wr(2'b00, 32'd3);
        check("col_load_out", {31'h0, bus.counter0_out}, 32'h0);
        step();
        step();
        wr(2'b00, 32'd7);
        check("col_out", {31'h0, bus.counter0_out}, 32'h0);
        step();
        check("col_cnt", bus.counter_out, 32'd7);
        bus.counter_set = 2'b11;
        step();
        check("col_ctrl", bus.counter_out, 32'h0000_0001);

        // Sticky flags, clear on control write, zero load in one-shot
        wr(2'b11, 32'h333);
        wr(2'b00, 32'd2);
        wr(2'b01, 32'd2);
        wr(2'b10, 32'd2);
        bus.counter_set = 2'b11;
        for (int w = 0; w < 6; w++) begin
            step();
        end
        check("flags_set", bus.counter_out, 32'h0000_7333);
        wr(2'b00, 32'd0);
        wr(2'b01, 32'd0);
        wr(2'b10, 32'd0);
        wr(2'b11, 32'h111);
        step();
        check("flags_clr", bus.counter_out, 32'h0000_0111);
        check("clr_outs", {29'h0, bus.counter2_out, bus.counter1_out, bus.counter0_out}, 32'h0);
        wr(2'b00, 32'd0);
        bus.counter_set = 2'b11;
        step();
        step();
        check("zero_out", {31'h0, bus.counter0_out}, 32'h0);
        check("zero_flag", bus.counter_out, 32'h0000_0111);

        // Asynchronous reset in the middle of counting
        wr(2'b11, 32'h3);
        wr(2'b00, 32'd2);
        step();
        step();
        check("pre_rst_out", {31'h0, bus.counter0_out}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out",  bus.counter_out, 32'h0);
        check("arst_outs", {29'h0, bus.counter2_out, bus.counter1_out, bus.counter0_out}, 32'h0);
        step();
        rst = 1'b1;
        step();
        check("arst_ctrl", bus.counter_out, 32'h0);
        bus.counter_set = 2'b00;
        for (int q = 0; q < 3; q++) begin
            step();
        end
        check("arst_cnt", bus.counter_out, 32'h0);
        check("arst_idle", {31'h0, bus.counter0_out}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
